main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
Lower-level memory responder that answers the L1 cache's lower-level request interface (addr/enable/write/data in; data/ready out). It replaces the always-ready main memory with a storage array that takes a configurable number of cycles per read and per write. This lets the L1 miss and writeback paths be exercised under realistic multi-cycle ready handshakes. It sits directly below the L1 inside the memory subsystem.

Parameters:
DATA_WIDTH, 32, width of a memory word
ADDR_WIDTH, 32, width of the request address (word address)
MEM_DEPTH, 4096, number of words in the array; power of two, at least 2
READ_LATENCY, 4, cycles from request acceptance to ready for a read; at least 1
WRITE_LATENCY, 2, cycles from request acceptance to ready for a write; at least 1

Ports:
clock  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
addrFromL1  in  ADDR_WIDTH  word address from L1
enableFromL1  in  1  request valid from L1
writeFromL1  in  1  request direction (0: read, 1: write)
dataFromL1  in  DATA_WIDTH  write data from L1
dataToL1  out  DATA_WIDTH  read data to L1; valid while readyToL1 is high, then held
readyToL1  out  1  one-cycle completion pulse to L1
busy  out  1  high while a request is latched and not yet completed
readCount  out  32  completed reads, saturating at all-ones
writeCount  out  32  completed writes, saturating at all-ones

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE; readyToL1=0, busy=0, dataToL1=0, readCount=0, writeCount=0, latency counter=0.
  - Array contents are not cleared.
- Indexing: idx = addrFromL1[log2(MEM_DEPTH)-1:0]. Upper address bits are ignored, so addresses alias modulo MEM_DEPTH.
- States: IDLE, WAIT, DONE.
- IDLE, when enableFromL1=1 in cycle T:
  - Latch addr, write and data; L = WRITE_LATENCY if write, else READ_LATENCY.
  - If L=1, go to DONE; otherwise load cnt=L-2 and go to WAIT.
  - busy=1 from T+1.
- WAIT: cnt decrements each cycle; at cnt=0, go to DONE. Inputs are ignored while in WAIT; only the latched request is served.
- Entering DONE (edge at end of cycle T+L-1), read: dataToL1 <= array[latched idx]. For a write, dataToL1 keeps its previous value.
- DONE (cycle T+L):
  - readyToL1=1 for exactly one cycle; enableFromL1 is ignored in this cycle.
  - At the edge ending DONE:
    - a write commits array[idx] <= latched data;
    - the matching counter increments unless already all-ones;
    - state returns to IDLE and busy=0.
- Throughput: a new request can be sampled in IDLE at cycle T+L+1, so back-to-back requests complete once every L+1 cycles.
- Ordering:
  - A read issued after a write to the same idx returns the written data.
  - Write commit always precedes any later array read.
- enable held high continuously: treated as a new request each time the block reaches IDLE.
- Reset mid-operation (WAIT or DONE): the request is aborted, no write is committed, and no ready pulse is produced after reset releases.
- Counter saturation: a counter at 0xFFFFFFFF stays at 0xFFFFFFFF.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum type (IDLE/WAIT/DONE);
  - an index-width localparam function based on $clog2(MEM_DEPTH);
  - a saturating increment function.
- One sub-module, word_ram:
  - single-port synchronous array with DATA_WIDTH x MEM_DEPTH;
  - registered read, write-enable input;
  - no reset on contents.

Test Plan:
- Reset release, then write addr=0x10 data=0xDEADBEEF (WRITE_LATENCY=2): readyToL1 high exactly in cycle T+2; writeCount=1; busy high only in cycles T+1..T+2.
- Read addr=0x10 (READ_LATENCY=4): readyToL1 in cycle T+4 with dataToL1=0xDEADBEEF; dataToL1 still holds 0xDEADBEEF after ready drops; readCount=1.
- Aliasing: write addr=0x1005 data=0x12345678, then read addr=0x0005 (MEM_DEPTH=4096) -> dataToL1=0x12345678.
- Back-to-back with enable held high over 3 reads: ready pulses at T+4, T+9 and T+14; input changes during WAIT do not affect returned data.
- Reset asserted in WAIT of a write to addr 0x20 data 0xFFFF0000, then read 0x20 -> old contents returned; no ready pulse follows the aborted write; both counters are 0 after reset.
- READ_LATENCY=1 and WRITE_LATENCY=1 build: ready in cycle T+1 for both directions; writeCount preloaded (forced) to 0xFFFFFFFE reaches 0xFFFFFFFF after one write and stays there after another.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the multi-cycle main memory responder.
// Holds the FSM state encoding, index-width helper and saturating increment.
// No logic of its own; imported by the responder and its storage array.
package mem_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Number of address bits needed to index a power-of-two deep array.
   function automatic int idx_width(input int depth);
      return $clog2(depth);
   endfunction

   // Event counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port synchronous word array with write enable and registered read.
// Latency: read data appears one edge after re_i; writes land on the same edge.
// No backpressure; contents are never reset.
module word_ram
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 4096,
   parameter int IW         = idx_width(MEM_DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [IW-1:0]         addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Storage write and registered read share the single address port.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/main_mem_responder.sv
// Main memory below the L1: answers one request at a time with a configurable latency.
// Latency: READ_LATENCY / WRITE_LATENCY cycles from acceptance to the readyToL1 pulse.
// Backpressure: busy while a request is in flight; enable is only sampled in IDLE.
module main_mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 32,
   parameter int MEM_DEPTH     = 4096,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addrFromL1,
   input  logic                  enableFromL1,
   input  logic                  writeFromL1,
   input  logic [DATA_WIDTH-1:0] dataFromL1,
   output logic [DATA_WIDTH-1:0] dataToL1,
   output logic                  readyToL1,
   output logic                  busy,
   output logic [31:0]           readCount,
   output logic [31:0]           writeCount
);

   localparam int          IW = idx_width(MEM_DEPTH);
   localparam logic [31:0] RL = READ_LATENCY;
   localparam logic [31:0] WL = WRITE_LATENCY;

   state_e                state_q;
   logic [31:0]           cnt_q;
   logic [IW-1:0]         idx_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  ready_q;
   logic                  busy_q;
   logic                  rd_seen_q;
   logic [31:0]           read_cnt_q;
   logic [31:0]           write_cnt_q;

   logic                  req_go;
   logic [31:0]           lat_sel;
   logic                  ram_re;
   logic                  ram_we;
   logic [IW-1:0]         ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  unused_addr_hi;

   assign req_go  = (state_q == S_IDLE) && enableFromL1;
   assign lat_sel = writeFromL1 ? WL : RL;

   // The array read happens on the edge that enters DONE, so the RAM's own
   // output register already holds the word during the ready cycle. With a
   // one-cycle read that edge is the acceptance edge, hence the live address.
   assign ram_re   = (req_go && !writeFromL1 && (RL == 32'd1)) ||
                     ((state_q == S_WAIT) && (cnt_q == 32'd0) && !write_q);
   assign ram_we   = (state_q == S_DONE) && write_q;
   assign ram_addr = (state_q == S_IDLE) ? addrFromL1[IW-1:0] : idx_q;

   assign unused_addr_hi = ^addrFromL1[ADDR_WIDTH-1:IW];

   word_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_ram (
      .clk_i   (clock),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   // Request FSM: latch in IDLE, count down in WAIT, pulse ready and retire in DONE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         rd_seen_q   <= 1'b0;
         read_cnt_q  <= '0;
         write_cnt_q <= '0;
      end else begin
         if (ram_re) begin
            rd_seen_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (enableFromL1) begin
                  idx_q   <= addrFromL1[IW-1:0];
                  write_q <= writeFromL1;
                  wdata_q <= dataFromL1;
                  busy_q  <= 1'b1;
                  if (lat_sel == 32'd1) begin
                     ready_q <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     cnt_q   <= lat_sel - 32'd2;
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == 32'd0) begin
                  ready_q <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 32'd1;
               end
            end
            S_DONE: begin
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
               if (write_q) begin
                  write_cnt_q <= sat_inc(write_cnt_q);
               end else begin
                  read_cnt_q <= sat_inc(read_cnt_q);
               end
            end
            default: begin
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Read data is zero until the first read after reset, then holds the last word read.
   assign dataToL1   = rd_seen_q ? ram_rdata : '0;
   assign readyToL1  = ready_q;
   assign busy       = busy_q;
   assign readCount  = read_cnt_q;
   assign writeCount = write_cnt_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized bench for main_mem_responder against a behavioural memory model.
// Two instances: default latencies (4/2, depth 4096) and a 1/1 latency, depth-16 build.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_main_mem_responder;

   logic        clock;
   logic        reset;
   logic [31:0] addr;
   logic        wr;
   logic [31:0] wdat;
   logic        en0, en1;
   logic [31:0] d0, d1, rc0, rc1, wc0, wc1;
   logic        rdy0, rdy1, bsy0, bsy1;

   int total_cnt;
   int bad_cnt;

   // behavioural model state
   logic [31:0] mem0 [4096];
   logic [31:0] mem1 [16];
   logic [31:0] m_rc [2];
   logic [31:0] m_wc [2];
   logic [31:0] m_last [2];

   main_mem_responder u_dut0 (
      .clock(clock), .reset(reset), .addrFromL1(addr), .enableFromL1(en0),
      .writeFromL1(wr), .dataFromL1(wdat), .dataToL1(d0), .readyToL1(rdy0),
      .busy(bsy0), .readCount(rc0), .writeCount(wc0)
   );

   main_mem_responder #(
      .MEM_DEPTH(16), .READ_LATENCY(1), .WRITE_LATENCY(1)
   ) u_dut1 (
      .clock(clock), .reset(reset), .addrFromL1(addr), .enableFromL1(en1),
      .writeFromL1(wr), .dataFromL1(wdat), .dataToL1(d1), .readyToL1(rdy1),
      .busy(bsy1), .readCount(rc1), .writeCount(wc1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 1;
   endfunction

   function automatic int lat(input int sel, input logic w);
      if (sel == 1) return 1;
      return w ? 2 : 4;
   endfunction

   // One complete request; entered and left at 1 time unit after a rising edge.
   task automatic req(input int sel, input logic [31:0] a, input logic w, input logic [31:0] dv);
      int          L;
      logic [31:0] exp_d;
      L = lat(sel, w);
      addr = a; wr = w; wdat = dv;
      if (sel == 1) en1 = 1'b1; else en0 = 1'b1;
      @(negedge clock);
      chk("idle_busy", {31'd0, sel == 1 ? bsy1 : bsy0}, 32'd0);
      chk("idle_ready", {31'd0, sel == 1 ? rdy1 : rdy0}, 32'd0);
      chk("data_hold", sel == 1 ? d1 : d0, m_last[sel]);
      chk("read_count", sel == 1 ? rc1 : rc0, m_rc[sel]);
      chk("write_count", sel == 1 ? wc1 : wc0, m_wc[sel]);
      @(posedge clock); #1;
      en0 = 1'b0; en1 = 1'b0;
      addr = $urandom; wr = 1'($urandom); wdat = $urandom;
      if (w) exp_d = m_last[sel];
      else   exp_d = (sel == 1) ? mem1[a % 16] : mem0[a % 4096];
      for (int k = 1; k <= L; k++) begin
         @(negedge clock);
         chk("busy", {31'd0, sel == 1 ? bsy1 : bsy0}, 32'd1);
         chk("ready", {31'd0, sel == 1 ? rdy1 : rdy0}, (k == L) ? 32'd1 : 32'd0);
         if (k == L) chk(w ? "data_keep_on_write" : "read_data", sel == 1 ? d1 : d0, exp_d);
         if (k < L) begin
            @(posedge clock); #1;
         end
      end
      @(posedge clock); #1;
      if (w) begin
         if (sel == 1) mem1[a % 16] = dv; else mem0[a % 4096] = dv;
         m_wc[sel] = sat(m_wc[sel]);
      end else begin
         m_rc[sel]   = sat(m_rc[sel]);
         m_last[sel] = exp_d;
      end
   endtask

   initial begin
      logic [31:0] alist [4];
      logic [31:0] a;
      logic        exp_r;
      total_cnt = 0; bad_cnt = 0;
      for (int i = 0; i < 2; i++) begin
         m_rc[i] = 0; m_wc[i] = 0; m_last[i] = 0;
      end
      reset = 1'b0; en0 = 1'b0; en1 = 1'b0; addr = 0; wr = 0; wdat = 0;

      // reset state
      @(negedge clock);
      chk("rst_ready", {31'd0, rdy0}, 32'd0);
      chk("rst_busy", {31'd0, bsy0}, 32'd0);
      chk("rst_data", d0, 32'd0);
      chk("rst_rcnt", rc0, 32'd0);
      chk("rst_wcnt", wc0, 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      // directed write/read and aliasing
      req(0, 32'h10, 1'b1, 32'hDEADBEEF);
      req(0, 32'h10, 1'b0, 32'h0);
      req(0, 32'h1005, 1'b1, 32'h12345678);
      req(0, 32'h0005, 1'b0, 32'h0);

      // fill low 16 words through random aliases, then random traffic
      for (int i = 0; i < 16; i++) begin
         a = ($urandom & 32'hFFFF_F000) | 32'(i);
         req(0, a, 1'b1, $urandom);
      end
      for (int i = 0; i < 40; i++) begin
         a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15));
         req(0, a, 1'($urandom), $urandom);
      end

      // enable held high across three reads; address wiggles during WAIT
      alist[0] = 32'h10; alist[1] = 32'h5; alist[2] = 32'h2003; alist[3] = 32'h7;
      en0 = 1'b1; wr = 1'b0;
      for (int c = 0; c < 16; c++) begin
         addr = alist[(c + 4) / 5];
         wdat = $urandom;
         if (c >= 11) en0 = 1'b0;
         @(negedge clock);
         exp_r = (c == 4) || (c == 9) || (c == 14);
         chk("b2b_ready", {31'd0, rdy0}, {31'd0, exp_r});
         if (exp_r) chk("b2b_data", d0, mem0[alist[(c - 4) / 5] % 4096]);
         @(posedge clock); #1;
      end
      m_rc[0] = sat(sat(sat(m_rc[0])));
      m_last[0] = mem0[alist[2] % 4096];

      // reset in WAIT of a write: aborted, nothing committed, no ready afterwards
      addr = 32'h20; wr = 1'b1; wdat = 32'hFFFF0000; en0 = 1'b1;
      @(posedge clock); #1;
      en0 = 1'b0;
      reset = 1'b0;
      #2;
      chk("abort_busy", {31'd0, bsy0}, 32'd0);
      chk("abort_ready", {31'd0, rdy0}, 32'd0);
      chk("abort_rcnt", rc0, 32'd0);
      chk("abort_wcnt", wc0, 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         m_rc[i] = 0; m_wc[i] = 0; m_last[i] = 0;
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         chk("abort_no_ready", {31'd0, rdy0}, 32'd0);
      end
      @(posedge clock); #1;
      req(0, 32'h20, 1'b0, 32'h0);

      // single-cycle build with aliasing over depth 16
      req(1, 32'h13, 1'b1, 32'hA5A5_0013);
      req(1, 32'h3, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++) begin
         req(1, $urandom, 1'b1, $urandom);
         req(1, $urandom, 1'b0, 32'h0);
      end

      // write counter saturation
      force u_dut1.write_cnt_q = 32'hFFFF_FFFE;
      @(posedge clock); #1;
      release u_dut1.write_cnt_q;
      m_wc[1] = 32'hFFFF_FFFE;
      req(1, 32'h1, 1'b1, 32'h1111_1111);
      req(1, 32'h2, 1'b1, 32'h2222_2222);
      @(negedge clock);
      chk("wcnt_saturated", wc1, m_wc[1]);
      chk("final_rcnt0", rc0, m_rc[0]);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total_cnt, bad_cnt);
      $fatal(1, "watchdog");
   end

endmodule
